// File: rtl/bitfield_pkg.sv
// Shared types for the bitfield pipe: op mode encoding and stage-1 control payload.
package bitfield_pkg;

  typedef enum logic [1:0] {
    BF_ROTMASK = 2'd0,
    BF_INSERT  = 2'd1,
    BF_FUNNEL  = 2'd2,
    BF_RSVD    = 2'd3
  } bf_mode_e;

  // Width-independent part of the stage-1 payload; the XLEN/TAG_W-sized
  // fields are held next to it in the top because they follow module parameters.
  typedef struct packed {
    bf_mode_e mode;
    logic     sx;    // sign-extend already qualified by ROTMASK && right
  } bf_s1_t;

endpackage

// File: rtl/bf_rotator.sv
// Combinational rotate of an XLEN word by SHW bits.
// Ports: data (word), sh (amount), left (1 = rotate left), result (rotated word).
module bf_rotator #(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] data,
  input  logic [SHW-1:0]  sh,
  input  logic            left,
  output logic [XLEN-1:0] result
);

  // Complementary amount is one bit wider so sh = 0 yields XLEN, shifting the wrap term out.
  logic [SHW:0] inv_sh;

  assign inv_sh = (SHW+1)'(XLEN) - (SHW+1)'(sh);
  assign result = left ? ((data << sh) | (data >> inv_sh))
                       : ((data >> sh) | (data << inv_sh));

endmodule

// File: rtl/bitfield_pipe.sv
// Two-stage pipelined bitfield unit: rotate/mask, field insert and funnel shift,
// with a valid/ready handshake on both sides and a tag carried per op.
// Ports: clk, rst_n (async active-low), flush (sync kill of all ops in flight);
//   in_valid/in_ready/in_mode/in_a/in_b/in_sh/in_mb/in_left/in_sx/in_tag (op input);
//   out_valid/out_ready/out_result/out_tag (result output).
module bitfield_pipe #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned TAG_W = 5,
  localparam int unsigned SHW   = $clog2(XLEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [SHW-1:0]   in_sh,
  input  logic [SHW-1:0]   in_mb,
  input  logic             in_left,
  input  logic             in_sx,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  import bitfield_pkg::*;

  logic             adv1, adv2;
  bf_mode_e         mode;
  logic             rot_left;
  logic [XLEN-1:0]  base, base_rev;
  logic [XLEN-1:0]  rot_data, rot_mask, fun_res;
  logic [XLEN-1:0]  s1_rot_d, s1_m_d;
  logic [SHW:0]     inv_sh;

  logic             s1_valid;
  bf_s1_t           s1;
  logic [XLEN-1:0]  s1_rot, s1_m, s1_b;
  logic [SHW-1:0]   s1_mb;
  logic [TAG_W-1:0] s1_tag;

  logic [XLEN-1:0]  merged, res_d;
  logic             sign_bit;

  logic             s2_valid;
  logic [XLEN-1:0]  s2_result;
  logic [TAG_W-1:0] s2_tag;

  // Handshake: each stage moves when the stage after it is free or draining.
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  assign mode     = bf_mode_e'(in_mode);
  assign rot_left = (mode == BF_INSERT) ? 1'b1 : in_left;
  assign base     = {XLEN{1'b1}} >> in_mb;

  for (genvar i = 0; i < int'(XLEN); i++) begin : g_rev
    assign base_rev[i] = base[XLEN-1-i];
  end

  bf_rotator #(.XLEN(XLEN)) u_rot_data (
    .data   (in_a),
    .sh     (in_sh),
    .left   (rot_left),
    .result (rot_data)
  );

  bf_rotator #(.XLEN(XLEN)) u_rot_mask (
    .data   (base),
    .sh     (in_sh),
    .left   (1'b1),
    .result (rot_mask)
  );

  // Funnel over {in_a,in_b}; the wide complementary shift makes sh = 0 select b (right) or a (left).
  assign inv_sh  = (SHW+1)'(XLEN) - (SHW+1)'(in_sh);
  assign fun_res = in_left ? ((in_a << in_sh) | (in_b >> inv_sh))
                           : ((in_b >> in_sh) | (in_a << inv_sh));

  // Stage-1 rotated word and mask selection per mode.
  always_comb begin
    s1_rot_d = rot_data;
    s1_m_d   = base;
    case (mode)
      BF_ROTMASK: s1_m_d   = in_left ? base_rev : base;
      BF_INSERT:  s1_m_d   = rot_mask;
      BF_FUNNEL:  s1_rot_d = fun_res;
      default:    s1_m_d   = base;
    endcase
  end

  // Stage-1 valid: flush beats accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        s1_valid <= 1'b0;
    else if (flush)    s1_valid <= 1'b0;
    else if (adv1)     s1_valid <= in_valid;
  end

  // Stage-1 payload, loaded only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '{mode: BF_ROTMASK, sx: 1'b0};
      s1_rot <= '0;
      s1_m   <= '0;
      s1_b   <= '0;
      s1_mb  <= '0;
      s1_tag <= '0;
    end else if (adv1 && in_valid) begin
      s1.mode <= mode;
      s1.sx   <= in_sx && !in_left && (mode == BF_ROTMASK);
      s1_rot  <= s1_rot_d;
      s1_m    <= s1_m_d;
      s1_b    <= in_b;
      s1_mb   <= in_mb;
      s1_tag  <= in_tag;
    end
  end

  // Stage-2 merge; field MSB index XLEN-1-mb equals ~mb because XLEN is a power of two.
  assign merged   = s1_rot & s1_m;
  assign sign_bit = merged[~s1_mb];

  always_comb begin
    res_d = '0;
    case (s1.mode)
      BF_ROTMASK: res_d = (s1.sx && sign_bit) ? (merged | ~s1_m) : merged;
      BF_INSERT:  res_d = merged | (s1_b & ~s1_m);
      BF_FUNNEL:  res_d = s1_rot;
      default:    res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        s2_valid <= 1'b0;
    else if (flush)    s2_valid <= 1'b0;
    else if (adv2)     s2_valid <= s1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_result <= '0;
      s2_tag    <= '0;
    end else if (adv2 && s1_valid) begin
      s2_result <= res_d;
      s2_tag    <= s1_tag;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_tag    = s2_tag;

endmodule

// File: tb/tb_bitfield_pipe.sv
// Self-checking bench for bitfield_pipe: directed spec cases, back-pressure,
// flush, mid-op reset and a randomized phase against a bit-level reference model.
module tb_bitfield_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [XLEN-1:0]  in_a, in_b;
  logic [SHW-1:0]   in_sh, in_mb;
  logic             in_left, in_sx;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  bitfield_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sh      (in_sh),
    .in_mb      (in_mb),
    .in_left    (in_left),
    .in_sx      (in_sx),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
    logic [31:0] spec;
    bit          has_spec;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  popped[$];
  int          cyc = 0;
  int          n_err = 0;
  int          n_chk = 0;
  bit          acc;
  bit          spec_en = 1'b0;
  logic [31:0] spec_val = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference computed bit by bit from the rotate/mask/insert/funnel rules.
  function automatic logic [31:0] model(input logic [1:0] mode, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh,
                                        input logic [4:0] mb, input bit left, input bit sx);
    logic [31:0] base, m, rot, r;
    logic [63:0] cat;
    int s, k;
    s = int'(sh);
    k = int'(mb);
    cat = {a, b};
    r = '0;
    for (int i = 0; i < 32; i++) base[i] = (i < 32 - k);
    case (mode)
      2'd0: begin
        for (int i = 0; i < 32; i++) begin
          rot[i] = left ? a[(i - s + 32) % 32] : a[(i + s) % 32];
          m[i]   = left ? base[31 - i] : base[i];
        end
        r = rot & m;
        if (sx && !left && r[31 - k]) r = r | ~m;
      end
      2'd1: begin
        for (int i = 0; i < 32; i++) begin
          rot[i] = a[(i - s + 32) % 32];
          m[i]   = base[(i - s + 32) % 32];
        end
        r = (rot & m) | (b & ~m);
      end
      2'd2: begin
        for (int i = 0; i < 32; i++) r[i] = left ? cat[i + 32 - s] : cat[i + s];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // One clock: sample at negedge, update scoreboard, return at posedge+1 for driving.
  task automatic cycle();
    exp_t e;
    bit   ov_exp;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
    ov_exp = (sb.size() > 0) && (cyc - sb[0].cyc >= 2);
    chk("out_valid", 32'(out_valid), 32'(ov_exp));
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      popped.push_back(out_tag);
      chk("out_tag", 32'(out_tag), 32'(e.tag));
      chk("out_result", out_result, e.res);
      if (e.has_spec) chk("spec_result", out_result, e.spec);
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e.res      = model(in_mode, in_a, in_b, in_sh, in_mb, in_left, in_sx);
      e.tag      = in_tag;
      e.cyc      = cyc;
      e.spec     = spec_val;
      e.has_spec = spec_en;
      sb.push_back(e);
    end
    if (flush) sb.delete();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [4:0] mb, input bit left,
                        input bit sx, input logic [4:0] tag);
    in_mode = mode; in_a = a; in_b = b; in_sh = sh; in_mb = mb;
    in_left = left; in_sx = sx; in_tag = tag;
  endtask

  task automatic issue(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] mb, input bit left,
                       input bit sx, input logic [4:0] tag, input logic [31:0] spec);
    set_op(mode, a, b, sh, mb, left, sx, tag);
    in_valid = 1'b1;
    spec_en  = 1'b1;
    spec_val = spec;
    acc      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("issue_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    spec_en  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic rand_op(input logic [4:0] tag);
    set_op(2'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'd0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rotate/mask cases, with explicit two-cycle latency on the first.
    issue(2'd0, 32'h800000F0, 32'h0, 5'd4, 5'd0, 1'b0, 1'b0, 5'd1, 32'h0800000F);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    cycle();
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    drain();
    issue(2'd0, 32'h00000F00, 32'h0, 5'd8, 5'd28, 1'b0, 1'b1, 5'd2, 32'hFFFFFFFF); drain();
    issue(2'd0, 32'h00000F00, 32'h0, 5'd8, 5'd28, 1'b0, 1'b0, 5'd3, 32'h0000000F); drain();
    issue(2'd0, 32'h0000ABCD, 32'h0, 5'd16, 5'd16, 1'b1, 1'b1, 5'd4, 32'hABCD0000); drain();
    // Insert and reserved mode.
    issue(2'd1, 32'h000000AB, 32'hFFFFFFFF, 5'd8, 5'd24, 1'b0, 1'b0, 5'd5, 32'hFFFFABFF); drain();
    issue(2'd3, 32'hDEADBEEF, 32'h12345678, 5'd3, 5'd2, 1'b1, 1'b1, 5'd7, 32'h0); drain();
    // Funnel, including sh = 0 edge.
    issue(2'd2, 32'h12345678, 32'h9ABCDEF0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 32'h789ABCDE); drain();
    issue(2'd2, 32'h12345678, 32'h9ABCDEF0, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 32'h3456789A); drain();
    issue(2'd2, 32'h12345678, 32'h9ABCDEF0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 32'h9ABCDEF0); drain();
    issue(2'd2, 32'h12345678, 32'h9ABCDEF0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd11, 32'h12345678); drain();

    // Back-pressure: tags 1..4, consumer stalled for four cycles.
    popped.delete();
    out_ready = 1'b0;
    rand_op(5'd1); in_valid = 1'b1; cycle(); chk("bp_acc1", 32'(acc), 32'd1);
    rand_op(5'd2); cycle(); chk("bp_acc2", 32'(acc), 32'd1);
    rand_op(5'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    cycle(); cycle();
    out_ready = 1'b1;
    cycle(); chk("bp_acc3", 32'(acc), 32'd1);
    rand_op(5'd4); cycle(); chk("bp_acc4", 32'(acc), 32'd1);
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("bp_order", 32'(popped[i]), 32'(i + 1));

    // Flush with two ops in flight plus one presented in the flush cycle.
    rand_op(5'd12); in_valid = 1'b1; cycle();
    rand_op(5'd13); cycle();
    rand_op(5'd14); flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (3) cycle();

    // Reset asserted with ops in flight.
    rand_op(5'd15); in_valid = 1'b1; cycle();
    rand_op(5'd16); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle();

    // Randomized traffic with stalls and occasional flushes.
    for (int n = 0; n < 1500; n++) begin
      rand_op(5'($urandom));
      in_valid  = ($urandom % 10) < 7;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 64) == 0;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
